// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package ssd_pkg;

  localparam int unsigned SSD_NUM_DIGITS = 8;

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } scan_state_e;

  // Anodes are active-low; this is the per-anode "dark" level, replicated across the bus.
  localparam logic AN_ALL_OFF = 1'b1;

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Word-load handshake between upstream logic and the scan driver.
interface ssd_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 8
) ();

  logic [4*NUM_DIGITS-1:0] data_in;
  logic                    data_valid;
  logic                    data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/ssd_refresh_tick.sv
// Free-running prescaler with clear/enable; pulses tick on the terminal count.
module ssd_refresh_tick #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] TERM = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = enable && !clear && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed scan driver for a common-anode seven-segment display with a
// one-deep pending word that is committed only on frame boundaries.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = SSD_NUM_DIGITS,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  ssd_scan_driver_if.slave      bus,
  input  logic                  display_en,
  input  logic                  lz_blank_en,
  output logic [3:0]            nibble,
  output logic                  digit_blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned WORD_W = 4 * NUM_DIGITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Bit i set when nibbles i..NUM_DIGITS-1 are all zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [WORD_W-1:0] word);
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    all_zero = 1'b1;
    mask     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      all_zero = all_zero && (word[4*i +: 4] == 4'h0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]     active_q, active_d;
  logic [WORD_W-1:0]     pending_q;
  logic                  pending_full_q, pending_full_d;
  logic                  accept, commit, wrap, tick, out_on;
  logic [NUM_DIGITS-1:0] zero_mask;
  logic [3:0]            nibble_d;
  logic                  blank_d;
  logic [NUM_DIGITS-1:0] an_d;

  ssd_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != SCAN),
    .enable (state_q == SCAN),
    .tick   (tick)
  );

  assign bus.data_ready = !pending_full_q;
  assign accept         = bus.data_valid && !pending_full_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    wrap    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idx_d  = '0;
        commit = pending_full_q;
        if (display_en) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!display_en) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tick) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap   = 1'b1;
            commit = pending_full_q;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit needs pending_full_q=1, so ready is low and accept cannot coincide.
  always_comb begin
    pending_full_d = pending_full_q;
    if (accept) begin
      pending_full_d = 1'b1;
    end else if (commit) begin
      pending_full_d = 1'b0;
    end
    active_d = commit ? pending_q : active_q;
  end

  assign out_on    = (state_q == SCAN) && display_en;
  assign zero_mask = lz_mask(active_q);

  always_comb begin
    nibble_d = 4'h0;
    blank_d  = 1'b1;
    an_d     = {NUM_DIGITS{AN_ALL_OFF}};
    if (out_on) begin
      nibble_d = active_q[4*idx_q +: 4];
      blank_d  = lz_blank_en && (idx_q != '0) && zero_mask[idx_q];
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        an_d[i] = (idx_q == IDX_W'(i)) ? ~AN_ALL_OFF : AN_ALL_OFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      nibble         <= 4'h0;
      digit_blank    <= 1'b1;
      an             <= {NUM_DIGITS{AN_ALL_OFF}};
      frame_tick     <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      active_q       <= active_d;
      pending_full_q <= pending_full_d;
      if (accept) begin
        pending_q <= bus.data_in;
      end
      nibble      <= nibble_d;
      digit_blank <= blank_d;
      an          <= an_d;
      frame_tick  <= wrap;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with 4 digits and a 4-cycle dwell.
module tb_ssd_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          display_en;
  logic          lz_blank_en;
  logic [3:0]    nibble;
  logic          digit_blank;
  logic [ND-1:0] an;
  logic          frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  ssd_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .display_en  (display_en),
    .lz_blank_en (lz_blank_en),
    .nibble      (nibble),
    .digit_blank (digit_blank),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'hF);
    check_eq({tag, "_blank"}, 32'(digit_blank), 32'h1);
    check_eq({tag, "_nibble"}, 32'(nibble), 32'h0);
  endtask

  // Steps through frame positions first..15; position k shows digit k/4.
  task automatic scan_frame(input string tag, input logic [15:0] word,
                            input logic [3:0] blank, input int first);
    int         ticks;
    int         d;
    logic [3:0] exp_nib;
    logic [3:0] exp_an;
    ticks = 0;
    for (int k = first; k < 16; k++) begin
      step();
      d       = k / 4;
      exp_nib = word[4*d +: 4];
      exp_an  = an_exp[d];
      check_eq($sformatf("%s_an_k%0d", tag, k), 32'(an), 32'(exp_an));
      check_eq($sformatf("%s_nib_k%0d", tag, k), 32'(nibble), 32'(exp_nib));
      check_eq($sformatf("%s_blank_k%0d", tag, k), 32'(digit_blank), 32'(blank[d]));
      if (frame_tick) ticks++;
    end
    check_eq({tag, "_ticks"}, 32'(ticks), 32'd1);
  endtask

  // Go dark, load a word while idle, then re-enter scanning at idx 0.
  task automatic restart(input string tag, input logic [15:0] word);
    display_en = 1'b0;
    step();
    check_off({tag, "_off"});
    bus.data_in    = word;
    bus.data_valid = 1'b1;
    step();
    check_eq({tag, "_ready_lo"}, 32'(bus.data_ready), 32'h0);
    bus.data_valid = 1'b0;
    step();
    check_eq({tag, "_ready_hi"}, 32'(bus.data_ready), 32'h1);
    display_en = 1'b1;
    step();
  endtask

  initial begin
    rst            = 1'b1;
    display_en     = 1'b0;
    lz_blank_en    = 1'b0;
    bus.data_in    = '0;
    bus.data_valid = 1'b0;

    // Reset state
    step();
    step();
    check_off("rst");
    check_eq("rst_tick", 32'(frame_tick), 32'h0);
    check_eq("rst_ready", 32'(bus.data_ready), 32'h1);
    rst = 1'b0;
    step();
    check_off("idle");

    // Basic scan of 12AF
    restart("t2", 16'h12AF);
    scan_frame("t2f0", 16'h12AF, 4'b0000, 0);
    scan_frame("t2f1", 16'h12AF, 4'b0000, 0);

    // Leading-zero suppression
    lz_blank_en = 1'b1;
    restart("t3a", 16'h0050);
    scan_frame("t3a", 16'h0050, 4'b1100, 0);
    restart("t3b", 16'h0000);
    scan_frame("t3b", 16'h0000, 4'b1110, 0);

    // Mid-frame load: old word held until the wrap, then a second word queues
    bus.data_in    = 16'hBEEF;
    bus.data_valid = 1'b1;
    step();
    check_eq("t4_ready_drop", 32'(bus.data_ready), 32'h0);
    check_eq("t4_k0_an", 32'(an), 32'hE);
    check_eq("t4_k0_nib", 32'(nibble), 32'h0);
    bus.data_in = 16'hCAFE;
    scan_frame("t4old", 16'h0000, 4'b1110, 1);
    check_eq("t4_ready_return", 32'(bus.data_ready), 32'h1);
    step();
    check_eq("t4_second_accept", 32'(bus.data_ready), 32'h0);
    bus.data_valid = 1'b0;
    check_eq("t4_new_an", 32'(an), 32'hE);
    check_eq("t4_new_nib", 32'(nibble), 32'hF);
    check_eq("t4_new_blank", 32'(digit_blank), 32'h0);
    scan_frame("t4beef", 16'hBEEF, 4'b0000, 1);
    scan_frame("t4cafe", 16'hCAFE, 4'b0000, 0);

    // Disable at idx 2, then restart with a full dwell
    repeat (9) step();
    check_eq("t5_idx2_an", 32'(an), 32'hB);
    display_en = 1'b0;
    step();
    check_off("t5_dark");
    step();
    check_off("t5_dark2");
    display_en = 1'b1;
    step();
    scan_frame("t5re", 16'hCAFE, 4'b0000, 0);

    // Reset mid-scan with a pending word
    bus.data_in    = 16'h1234;
    bus.data_valid = 1'b1;
    step();
    check_eq("t6_pending", 32'(bus.data_ready), 32'h0);
    bus.data_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_off("t6_rst");
    check_eq("t6_tick", 32'(frame_tick), 32'h0);
    check_eq("t6_ready", 32'(bus.data_ready), 32'h1);
    rst = 1'b0;
    step();
    scan_frame("t6zero", 16'h0000, 4'b1110, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
